// File: rtl/t_toggle_bank.sv
// t_toggle_bank: WIDTH-bit bank of T flip-flops sharing one clock.
// Runs as independent per-bit toggles, as an up/down counter whose T inputs come
// from an internal carry chain, or as a parallel-load register. A registered
// event_pulse flags a wrap (or a saturation hit) in the previous enabled cycle.
module t_toggle_bank #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_inverse,
    output logic             event_pulse
);

    typedef enum logic [1:0] {
        ModeToggle = 2'b00,
        ModeUp     = 2'b01,
        ModeDown   = 2'b10,
        ModeLoad   = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             event_q, event_d;
    logic [WIDTH-1:0] ones_below;   // bit i: all of q[i-1:0] are 1
    logic [WIDTH-1:0] zeros_below;  // bit i: all of q[i-1:0] are 0
    logic [WIDTH-1:0] t_eff;
    logic             at_max, at_min;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);
    assign at_max   = &q_q;
    assign at_min   = ~|q_q;

    // Carry/borrow chains that produce the counter-mode T inputs.
    always_comb begin
        ones_below     = '0;
        zeros_below    = '0;
        ones_below[0]  = 1'b1;
        zeros_below[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            ones_below[i]  = ones_below[i-1] & q_q[i-1];
            zeros_below[i] = zeros_below[i-1] & ~q_q[i-1];
        end
    end

    // Effective per-bit toggle vector and next-state; load is expressed as a toggle of q ^ d.
    always_comb begin
        t_eff   = '0;
        event_d = 1'b0;
        unique case (mode_sel)
            ModeToggle: t_eff = t;
            ModeUp: begin
                t_eff   = (SATURATE && at_max) ? '0 : ones_below;
                event_d = at_max;
            end
            ModeDown: begin
                t_eff   = (SATURATE && at_min) ? '0 : zeros_below;
                event_d = at_min;
            end
            ModeLoad: t_eff = q_q ^ d;
            default:  t_eff = '0;
        endcase
        q_d = q_q ^ t_eff;
        if (!en) begin
            q_d     = q_q;
            event_d = 1'b0;
        end
    end

    // State registers; reset also clears any pending event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= RESET_VALUE;
            event_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            event_q <= event_d;
        end
    end

    // Inverter on the register keeps q_inverse exactly ~q, reset included.
    assign q           = q_q;
    assign q_inverse   = ~q_q;
    assign event_pulse = event_q;

endmodule

// File: tb/tb_t_toggle_bank.sv
// Self-checking bench for t_toggle_bank: a wrapping 8-bit bank, a saturating 8-bit
// bank with non-zero reset value, and a 1-bit bank, all on one clock and reset.
module tb_t_toggle_bank;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] t;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_ev;
    } vec_t;

    typedef struct {
        int         sel;
        logic [7:0] q;
        logic       ev;
        string      name;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic [1:0] mode_a = 2'b00, mode_b = 2'b00, mode_c = 2'b00;
    logic [7:0] t_a = '0, d_a = '0, t_b = '0, d_b = '0;
    logic [0:0] t_c = '0, d_c = '0;
    logic [7:0] q_a, qi_a, q_b, qi_b;
    logic [0:0] q_c, qi_c;
    logic       ev_a, ev_b, ev_c;

    int n_vec = 0;
    int n_err = 0;
    sb_t sbq[$];
    vec_t tbl[20];

    always #5 clk = ~clk;

    t_toggle_bank #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .t(t_a), .d(d_a),
        .q(q_a), .q_inverse(qi_a), .event_pulse(ev_a)
    );

    t_toggle_bank #(.WIDTH(8), .RESET_VALUE(8'h5A), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .t(t_b), .d(d_b),
        .q(q_b), .q_inverse(qi_b), .event_pulse(ev_b)
    );

    t_toggle_bank #(.WIDTH(1), .RESET_VALUE(1'b0), .SATURATE(1'b0)) u_one (
        .clk(clk), .rst_n(rst_n), .en(en_c), .mode(mode_c), .t(t_c), .d(d_c),
        .q(q_c), .q_inverse(qi_c), .event_pulse(ev_c)
    );

    function automatic vec_t mk(input logic e, input logic [1:0] m, input logic [7:0] tv,
                                input logic [7:0] dv, input logic [7:0] eq, input logic ee);
        vec_t v;
        v.en = e; v.mode = m; v.t = tv; v.d = dv; v.exp_q = eq; v.exp_ev = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Compare one DUT's outputs against expected q / event; q_inverse must be ~q.
    task automatic compare(input int sel, input logic [7:0] eq, input logic ee, input string nm);
        logic [7:0] aq, aqi, mask;
        logic       aev;
        case (sel)
            0:       begin aq = q_a; aqi = qi_a; aev = ev_a; mask = 8'hFF; end
            1:       begin aq = q_b; aqi = qi_b; aev = ev_b; mask = 8'hFF; end
            default: begin aq = {7'b0, q_c}; aqi = {7'b0, qi_c}; aev = ev_c; mask = 8'h01; end
        endcase
        check({nm, " q"}, aq, eq & mask);
        check({nm, " q_inverse"}, aqi, ~eq & mask);
        check({nm, " event_pulse"}, {7'b0, aev}, {7'b0, ee});
    endtask

    // Drive one cycle of stimulus to the selected DUT (others held with en=0).
    task automatic step(input int sel, input logic e, input logic [1:0] m, input logic [7:0] tv,
                        input logic [7:0] dv, input logic [7:0] eq, input logic ee,
                        input string nm);
        sb_t s;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        case (sel)
            0:       begin en_a = e; mode_a = m; t_a = tv; d_a = dv; end
            1:       begin en_b = e; mode_b = m; t_b = tv; d_b = dv; end
            default: begin en_c = e; mode_c = m; t_c = tv[0:0]; d_c = dv[0:0]; end
        endcase
        s.sel = sel; s.q = eq; s.ev = ee; s.name = nm;
        sbq.push_back(s);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard %s: got empty queue, expected one entry", nm);
        end else begin
            s = sbq.pop_front();
            compare(s.sel, s.q, s.ev, s.name);
        end
    endtask

    task automatic check_reset_all(input string nm);
        compare(0, 8'h00, 1'b0, {nm, " wrap"});
        compare(1, 8'h5A, 1'b0, {nm, " sat"});
        compare(2, 8'h00, 1'b0, {nm, " one"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset from power-up, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset_all("por");
        #6 rst_n = 1'b1;

        // Main table on the wrapping bank.
        tbl[0]  = mk(1, 2'b11, 8'h00, 8'h0F, 8'h0F, 0);
        tbl[1]  = mk(1, 2'b00, 8'h3C, 8'h00, 8'h33, 0);
        tbl[2]  = mk(1, 2'b00, 8'h00, 8'hFF, 8'h33, 0);
        tbl[3]  = mk(1, 2'b00, 8'hFF, 8'h00, 8'hCC, 0);
        tbl[4]  = mk(1, 2'b11, 8'h00, 8'hFE, 8'hFE, 0);
        tbl[5]  = mk(1, 2'b01, 8'hFF, 8'h00, 8'hFF, 0);
        tbl[6]  = mk(1, 2'b01, 8'h00, 8'h00, 8'h00, 1);
        tbl[7]  = mk(1, 2'b01, 8'h00, 8'h00, 8'h01, 0);
        tbl[8]  = mk(1, 2'b11, 8'h00, 8'h10, 8'h10, 0);
        tbl[9]  = mk(1, 2'b01, 8'h00, 8'h00, 8'h11, 0);
        tbl[10] = mk(0, 2'b01, 8'h00, 8'h00, 8'h11, 0);
        tbl[11] = mk(1, 2'b01, 8'h00, 8'h00, 8'h12, 0);
        tbl[12] = mk(1, 2'b11, 8'h00, 8'hFF, 8'hFF, 0);
        tbl[13] = mk(1, 2'b11, 8'h00, 8'h80, 8'h80, 0);
        tbl[14] = mk(1, 2'b10, 8'h00, 8'h00, 8'h7F, 0);
        tbl[15] = mk(1, 2'b01, 8'h00, 8'h00, 8'h80, 0);
        tbl[16] = mk(1, 2'b11, 8'h00, 8'h00, 8'h00, 0);
        tbl[17] = mk(1, 2'b10, 8'h00, 8'h00, 8'hFF, 1);
        tbl[18] = mk(0, 2'b11, 8'h00, 8'hAA, 8'hFF, 0);
        tbl[19] = mk(1, 2'b10, 8'h00, 8'h00, 8'hFE, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, tbl[i].en, tbl[i].mode, tbl[i].t, tbl[i].d, tbl[i].exp_q, tbl[i].exp_ev,
                 $sformatf("tbl[%0d]", i));
        end

        // Asynchronous reset between edges with q=A5, held across an enabled edge.
        step(0, 1, 2'b11, 8'h00, 8'hA5, 8'hA5, 0, "load_a5");
        #3 rst_n = 1'b0;
        #1 check_reset_all("async_rst");
        en_a = 1'b1; mode_a = 2'b01;
        @(posedge clk);
        #1 compare(0, 8'h00, 1'b0, "rst_held");
        en_a = 1'b0;
        #3 rst_n = 1'b1;
        step(0, 0, 2'b01, 8'h00, 8'h00, 8'h00, 0, "post_rst_en0");

        // Saturating bank: down from 01 sticks at 00, then up sticks at FF.
        step(1, 1, 2'b11, 8'h00, 8'h01, 8'h01, 0, "sat_load01");
        step(1, 1, 2'b10, 8'h00, 8'h00, 8'h00, 0, "sat_dn1");
        step(1, 1, 2'b10, 8'h00, 8'h00, 8'h00, 1, "sat_dn2");
        step(1, 1, 2'b10, 8'h00, 8'h00, 8'h00, 1, "sat_dn3");
        step(1, 1, 2'b11, 8'h00, 8'hFE, 8'hFE, 0, "sat_loadfe");
        step(1, 1, 2'b01, 8'h00, 8'h00, 8'hFF, 0, "sat_up1");
        step(1, 1, 2'b01, 8'h00, 8'h00, 8'hFF, 1, "sat_up2");
        step(1, 1, 2'b01, 8'h00, 8'h00, 8'hFF, 1, "sat_up3");
        step(1, 0, 2'b01, 8'h00, 8'h00, 8'hFF, 0, "sat_en0");
        step(1, 1, 2'b10, 8'h00, 8'h00, 8'hFE, 0, "sat_dn_from_ff");

        // WIDTH=1: both counter modes toggle; events on 1->0 up and 0->1 down.
        step(2, 1, 2'b11, 8'h00, 8'h00, 8'h00, 0, "one_load0");
        step(2, 1, 2'b01, 8'h00, 8'h00, 8'h01, 0, "one_up1");
        step(2, 1, 2'b01, 8'h00, 8'h00, 8'h00, 1, "one_up2");
        step(2, 1, 2'b01, 8'h00, 8'h00, 8'h01, 0, "one_up3");
        step(2, 1, 2'b10, 8'h00, 8'h00, 8'h00, 0, "one_dn1");
        step(2, 1, 2'b10, 8'h00, 8'h00, 8'h01, 1, "one_dn2");
        step(2, 1, 2'b00, 8'h01, 8'h00, 8'h00, 0, "one_tog1");
        step(2, 1, 2'b00, 8'h00, 8'h00, 8'h00, 0, "one_tog0");

        // Reset for half a cycle while counting at 7F; counting resumes from reset value.
        step(0, 1, 2'b11, 8'h00, 8'h7E, 8'h7E, 0, "mid_load7e");
        step(0, 1, 2'b01, 8'h00, 8'h00, 8'h7F, 0, "mid_up7f");
        #3 rst_n = 1'b0;
        #1 compare(0, 8'h00, 1'b0, "mid_rst");
        #4 rst_n = 1'b1;
        step(0, 1, 2'b01, 8'h00, 8'h00, 8'h01, 0, "mid_resume");

        // Reset clears a pending event_pulse.
        step(0, 1, 2'b11, 8'h00, 8'hFF, 8'hFF, 0, "ev_loadff");
        step(0, 1, 2'b01, 8'h00, 8'h00, 8'h00, 1, "ev_wrap");
        #3 rst_n = 1'b0;
        #1 compare(0, 8'h00, 1'b0, "ev_rst_clear");
        #4 rst_n = 1'b1;
        step(0, 1, 2'b01, 8'h00, 8'h00, 8'h01, 0, "ev_resume");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
